// File: rtl/cmd_scheduler.sv
`default_nettype none

// ============================================================================
// Package     : accel_pkg
// Description : Opcode and compute-type encodings shared by the decoder,
//               the command scheduler and the execution units.
// Revision    : 1.0 - initial release
// ============================================================================
package accel_pkg;

    typedef enum logic [2:0] {
        OP_NOP     = 3'd0,
        OP_LOAD    = 3'd1,
        OP_STORE   = 3'd2,
        OP_COMPUTE = 3'd3,
        OP_COPY    = 3'd4,
        OP_ADD_VEC = 3'd5
    } op_code_t;

    typedef enum logic [1:0] {
        COMP_ADD  = 2'd0,
        COMP_MUL  = 2'd1,
        COMP_MAC  = 2'd2,
        COMP_RELU = 2'd3
    } comp_type_t;

endpackage

// ============================================================================
// Module      : cmd_scheduler
// Description : In-order command scheduler. Buffers decoded commands in a
//               small FIFO and issues the head to its destination unit with a
//               one-cycle start pulse once the destination (and the source,
//               for COPY/ADD_VEC) is idle. OP_NOP fences until all units are
//               idle. Malformed commands are dropped with sticky errors.
// Ports       : clk/rst          - clock, synchronous active-high reset
//               cmd_*            - decoder command channel (valid/ready)
//               flush            - synchronous FIFO clear
//               unit_done        - per-unit completion pulses
//               unit_start       - registered one-hot start pulse
//               issue_op/comp/src- command fields qualified by unit_start
//               busy_units       - registered unit reservation bitmap
//               fifo_level       - number of queued commands
//               sched_idle       - nothing queued and no unit reserved
//               err_status/count - sticky error flags and saturating count
//               err_clr          - clears err_status and err_count
// Revision    : 1.0 - initial release
// ============================================================================
module cmd_scheduler #(
    parameter int UNIT_COUNT = 4,
    parameter int UNIT_ID_W  = 4,
    parameter int DEPTH      = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic                       cmd_decode_ok,
    input  accel_pkg::op_code_t        cmd_op,
    input  accel_pkg::comp_type_t      cmd_comp,
    input  logic [UNIT_ID_W-1:0]       cmd_unit_id,
    input  logic [UNIT_ID_W-1:0]       cmd_src_unit_id,
    input  logic                       flush,
    input  logic [UNIT_COUNT-1:0]      unit_done,
    output logic [UNIT_COUNT-1:0]      unit_start,
    output accel_pkg::op_code_t        issue_op,
    output accel_pkg::comp_type_t      issue_comp,
    output logic [UNIT_ID_W-1:0]       issue_src,
    output logic [UNIT_COUNT-1:0]      busy_units,
    output logic [$clog2(DEPTH):0]     fifo_level,
    output logic                       sched_idle,
    output logic [2:0]                 err_status,
    input  logic                       err_clr,
    output logic [7:0]                 err_count
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;

    localparam logic [c_cnt_w-1:0]    c_full_level = c_cnt_w'(DEPTH);
    localparam logic [c_cnt_w-1:0]    c_one_level  = c_cnt_w'(1);
    localparam logic [UNIT_ID_W:0]    c_unit_lim   = (UNIT_ID_W + 1)'(UNIT_COUNT);
    localparam logic [UNIT_COUNT-1:0] c_unit_one   = UNIT_COUNT'(1);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_issue = 2'd1;
    localparam logic [1:0] c_st_stall = 2'd2;
    localparam logic [1:0] c_st_fence = 2'd3;

    // ------------------------------------------------------------------
    // Command FIFO storage
    // ------------------------------------------------------------------
    accel_pkg::op_code_t   r_mem_op   [DEPTH];
    accel_pkg::comp_type_t r_mem_comp [DEPTH];
    logic [UNIT_ID_W-1:0]  r_mem_unit [DEPTH];
    logic [UNIT_ID_W-1:0]  r_mem_src  [DEPTH];

    logic [c_ptr_w-1:0]    r_wr_ptr;
    logic [c_ptr_w-1:0]    r_rd_ptr;
    logic [c_cnt_w-1:0]    r_count;

    logic [1:0]            r_state;
    logic [UNIT_COUNT-1:0] r_busy;
    logic [UNIT_COUNT-1:0] r_unit_start;
    accel_pkg::op_code_t   r_issue_op;
    accel_pkg::comp_type_t r_issue_comp;
    logic [UNIT_ID_W-1:0]  r_issue_src;
    logic [2:0]            r_err_status;
    logic [7:0]            r_err_count;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_ready;
    logic                  w_xfer;
    logic                  w_push;
    logic                  w_dec_err;

    accel_pkg::op_code_t   w_head_op;
    accel_pkg::comp_type_t w_head_comp;
    logic [UNIT_ID_W-1:0]  w_head_unit;
    logic [UNIT_ID_W-1:0]  w_head_src;
    logic                  w_head_src_op;
    logic                  w_head_bad;
    logic [UNIT_COUNT-1:0] w_dst_mask;
    logic [UNIT_COUNT-1:0] w_src_mask;
    logic                  w_units_free;
    logic                  w_drain;

    logic                  w_issue;
    logic                  w_pop;
    logic                  w_err_unit;
    logic [1:0]            w_next_state;

    logic [UNIT_COUNT-1:0] w_spur;
    logic [7:0]            w_evt_cnt;
    logic [8:0]            w_cnt_sum;

    assign w_full    = (r_count == c_full_level);
    assign w_empty   = (r_count == '0);
    assign w_ready   = !w_full && !rst && !flush;
    assign w_xfer    = cmd_valid && w_ready;
    assign w_push    = w_xfer && cmd_decode_ok;
    assign w_dec_err = w_xfer && !cmd_decode_ok;

    assign w_head_op   = r_mem_op[r_rd_ptr];
    assign w_head_comp = r_mem_comp[r_rd_ptr];
    assign w_head_unit = r_mem_unit[r_rd_ptr];
    assign w_head_src  = r_mem_src[r_rd_ptr];

    assign w_head_src_op = (w_head_op == accel_pkg::OP_COPY) ||
                           (w_head_op == accel_pkg::OP_ADD_VEC);
    assign w_head_bad    = ({1'b0, w_head_unit} >= c_unit_lim) ||
                           (w_head_src_op && ({1'b0, w_head_src} >= c_unit_lim));

    // Masks are only consulted once the IDs are known to be in range.
    assign w_dst_mask   = c_unit_one << w_head_unit;
    assign w_src_mask   = w_head_src_op ? (c_unit_one << w_head_src) : '0;
    assign w_units_free = ((r_busy & (w_dst_mask | w_src_mask)) == '0);

    // FIFO becomes empty if this pop takes the last entry and nothing arrives.
    assign w_drain = (r_count == c_one_level) && !w_push;

    // ------------------------------------------------------------------
    // Head decision: exactly one per cycle
    // ------------------------------------------------------------------
    always_comb begin
        w_issue      = 1'b0;
        w_pop        = 1'b0;
        w_err_unit   = 1'b0;
        w_next_state = r_state;
        case (r_state)
            c_st_idle: begin
                if (!w_empty || w_push) begin
                    w_next_state = c_st_issue;
                end
            end
            c_st_issue, c_st_stall: begin
                if (w_empty) begin
                    w_next_state = c_st_idle;
                end else if (w_head_bad) begin
                    w_pop        = 1'b1;
                    w_err_unit   = 1'b1;
                    w_next_state = w_drain ? c_st_idle : c_st_issue;
                end else if (w_head_op == accel_pkg::OP_NOP) begin
                    w_next_state = c_st_fence;
                end else if (w_units_free) begin
                    w_pop        = 1'b1;
                    w_issue      = 1'b1;
                    w_next_state = w_drain ? c_st_idle : c_st_issue;
                end else begin
                    w_next_state = c_st_stall;
                end
            end
            c_st_fence: begin
                if (r_busy == '0) begin
                    w_pop        = 1'b1;
                    w_next_state = w_drain ? c_st_idle : c_st_issue;
                end
            end
            default: w_next_state = c_st_idle;
        endcase
        // Flush wins over any head action in the same cycle.
        if (flush) begin
            w_issue      = 1'b0;
            w_pop        = 1'b0;
            w_err_unit   = 1'b0;
            w_next_state = c_st_idle;
        end
    end

    // ------------------------------------------------------------------
    // Error event accounting
    // ------------------------------------------------------------------
    assign w_spur = unit_done & ~r_busy;

    always_comb begin
        w_evt_cnt = {7'd0, w_err_unit} + {7'd0, w_dec_err};
        for (int i = 0; i < UNIT_COUNT; i++) begin
            w_evt_cnt = w_evt_cnt + {7'd0, w_spur[i]};
        end
    end

    assign w_cnt_sum = {1'b0, r_err_count} + {1'b0, w_evt_cnt};

    // ------------------------------------------------------------------
    // FIFO storage write (payload needs no reset)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_op[r_wr_ptr]   <= cmd_op;
            r_mem_comp[r_wr_ptr] <= cmd_comp;
            r_mem_unit[r_wr_ptr] <= cmd_unit_id;
            r_mem_src[r_wr_ptr]  <= cmd_src_unit_id;
        end
    end

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_state      <= c_st_idle;
            r_busy       <= '0;
            r_unit_start <= '0;
            r_issue_op   <= accel_pkg::OP_NOP;
            r_issue_comp <= accel_pkg::COMP_ADD;
            r_issue_src  <= '0;
            r_err_status <= '0;
            r_err_count  <= '0;
        end else begin
            r_state <= w_next_state;

            if (flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
                end
                if (w_push && !w_pop) begin
                    r_count <= r_count + c_one_level;
                end else if (!w_push && w_pop) begin
                    r_count <= r_count - c_one_level;
                end
            end

            // Done releases only reserved units; a new issue never targets a
            // reserved unit, so set and clear never collide on one bit.
            r_busy <= (r_busy & ~unit_done) | (w_issue ? w_dst_mask : '0);

            if (w_issue) begin
                r_unit_start <= w_dst_mask;
                r_issue_op   <= w_head_op;
                r_issue_comp <= w_head_comp;
                r_issue_src  <= w_head_src;
            end else begin
                r_unit_start <= '0;
                r_issue_op   <= accel_pkg::OP_NOP;
                r_issue_comp <= accel_pkg::COMP_ADD;
                r_issue_src  <= '0;
            end

            if (err_clr) begin
                r_err_status <= '0;
                r_err_count  <= '0;
            end else begin
                r_err_status <= r_err_status | {(w_spur != '0), w_dec_err, w_err_unit};
                r_err_count  <= w_cnt_sum[8] ? 8'hFF : w_cnt_sum[7:0];
            end
        end
    end

    assign cmd_ready  = w_ready;
    assign unit_start = r_unit_start;
    assign issue_op   = r_issue_op;
    assign issue_comp = r_issue_comp;
    assign issue_src  = r_issue_src;
    assign busy_units = r_busy;
    assign fifo_level = r_count;
    assign sched_idle = w_empty && (r_busy == '0) && !rst;
    assign err_status = r_err_status;
    assign err_count  = r_err_count;

endmodule

`default_nettype wire

// File: tb/tb_cmd_scheduler.sv
`default_nettype none

// ============================================================================
// Module      : tb_cmd_scheduler
// Description : Directed self-checking bench for cmd_scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cmd_scheduler;
    import accel_pkg::*;

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_decode_ok;
    op_code_t         cmd_op;
    comp_type_t       cmd_comp;
    logic [3:0]       cmd_unit_id;
    logic [3:0]       cmd_src_unit_id;
    logic             flush;
    logic [3:0]       unit_done;
    logic [3:0]       unit_start;
    op_code_t         issue_op;
    comp_type_t       issue_comp;
    logic [3:0]       issue_src;
    logic [3:0]       busy_units;
    logic [2:0]       fifo_level;
    logic             sched_idle;
    logic [2:0]       err_status;
    logic             err_clr;
    logic [7:0]       err_count;

    int n_checks = 0;
    int n_errors = 0;

    cmd_scheduler #(.UNIT_COUNT(4), .UNIT_ID_W(4), .DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_decode_ok(cmd_decode_ok),
        .cmd_op(cmd_op), .cmd_comp(cmd_comp), .cmd_unit_id(cmd_unit_id),
        .cmd_src_unit_id(cmd_src_unit_id), .flush(flush), .unit_done(unit_done),
        .unit_start(unit_start), .issue_op(issue_op), .issue_comp(issue_comp),
        .issue_src(issue_src), .busy_units(busy_units), .fifo_level(fifo_level),
        .sched_idle(sched_idle), .err_status(err_status), .err_clr(err_clr),
        .err_count(err_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout got running want finished");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input op_code_t op, input logic [3:0] u, input logic [3:0] s);
        cmd_valid = 1'b1; cmd_decode_ok = 1'b1; cmd_op = op;
        cmd_comp = COMP_MUL; cmd_unit_id = u; cmd_src_unit_id = s;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic pulse_done(input logic [3:0] m);
        unit_done = m;
        tick();
        unit_done = 4'b0000;
    endtask

    task automatic test_reset();
        rst = 1'b1; cmd_valid = 1'b0; cmd_decode_ok = 1'b1; cmd_op = OP_NOP;
        cmd_comp = COMP_ADD; cmd_unit_id = 4'd0; cmd_src_unit_id = 4'd0;
        flush = 1'b0; unit_done = 4'b0000; err_clr = 1'b0;
        tick(); tick();
        n_checks++;
        if (cmd_ready !== 1'b0 || busy_units !== 4'b0 || err_status !== 3'b0 ||
            err_count !== 8'd0 || unit_start !== 4'b0 || fifo_level !== 3'd0) begin
            n_errors++;
            $display("FAIL reset_outputs got rdy=%b busy=%b err=%b cnt=%0d start=%b lvl=%0d want all 0",
                     cmd_ready, busy_units, err_status, err_count, unit_start, fifo_level);
        end
        rst = 1'b0;
        tick();
        n_checks++;
        if (cmd_ready !== 1'b1 || sched_idle !== 1'b1) begin
            n_errors++;
            $display("FAIL post_reset got rdy=%b idle=%b want 1 1", cmd_ready, sched_idle);
        end
    endtask

    task automatic test_load();
        push(OP_LOAD, 4'd1, 4'd0);
        n_checks++;
        if (unit_start !== 4'b0000 || fifo_level !== 3'd1) begin
            n_errors++;
            $display("FAIL load_queued got start=%b lvl=%0d want 0000 1", unit_start, fifo_level);
        end
        tick();
        n_checks++;
        if (unit_start !== 4'b0010 || busy_units !== 4'b0010 || issue_op !== OP_LOAD ||
            issue_comp !== COMP_MUL || fifo_level !== 3'd0) begin
            n_errors++;
            $display("FAIL load_start got start=%b busy=%b op=%0d comp=%0d lvl=%0d want 0010 0010 1 1 0",
                     unit_start, busy_units, issue_op, issue_comp, fifo_level);
        end
        tick();
        n_checks++;
        if (unit_start !== 4'b0000 || issue_op !== OP_NOP) begin
            n_errors++;
            $display("FAIL load_pulse_width got start=%b op=%0d want 0000 0", unit_start, issue_op);
        end
        tick(); tick();
        pulse_done(4'b0010);
        n_checks++;
        if (busy_units !== 4'b0000 || sched_idle !== 1'b1) begin
            n_errors++;
            $display("FAIL load_done got busy=%b idle=%b want 0000 1", busy_units, sched_idle);
        end
    endtask

    task automatic test_back_to_back();
        push(OP_LOAD, 4'd0, 4'd0);
        push(OP_LOAD, 4'd1, 4'd0);
        n_checks++;
        if (unit_start !== 4'b0001) begin
            n_errors++;
            $display("FAIL b2b_first got %b want 0001", unit_start);
        end
        push(OP_LOAD, 4'd2, 4'd0);
        n_checks++;
        if (unit_start !== 4'b0010) begin
            n_errors++;
            $display("FAIL b2b_second got %b want 0010", unit_start);
        end
        tick();
        n_checks++;
        if (unit_start !== 4'b0100 || busy_units !== 4'b0111) begin
            n_errors++;
            $display("FAIL b2b_third got start=%b busy=%b want 0100 0111", unit_start, busy_units);
        end
        pulse_done(4'b0111);
        n_checks++;
        if (busy_units !== 4'b0000 || err_status !== 3'b000) begin
            n_errors++;
            $display("FAIL b2b_done got busy=%b err=%b want 0000 000", busy_units, err_status);
        end
    endtask

    task automatic test_copy_stall();
        push(OP_COMPUTE, 4'd2, 4'd0);
        push(OP_COPY, 4'd3, 4'd2);
        n_checks++;
        if (unit_start !== 4'b0100) begin
            n_errors++;
            $display("FAIL copy_compute_start got %b want 0100", unit_start);
        end
        tick(); tick(); tick();
        n_checks++;
        if (unit_start !== 4'b0000 || fifo_level !== 3'd1 || busy_units !== 4'b0100) begin
            n_errors++;
            $display("FAIL copy_stalled got start=%b lvl=%0d busy=%b want 0000 1 0100",
                     unit_start, fifo_level, busy_units);
        end
        pulse_done(4'b0100);
        n_checks++;
        if (unit_start !== 4'b0000 || busy_units !== 4'b0000) begin
            n_errors++;
            $display("FAIL copy_at_done got start=%b busy=%b want 0000 0000", unit_start, busy_units);
        end
        tick();
        n_checks++;
        if (unit_start !== 4'b1000 || issue_op !== OP_COPY || issue_src !== 4'd2 ||
            busy_units !== 4'b1000) begin
            n_errors++;
            $display("FAIL copy_issue got start=%b op=%0d src=%0d busy=%b want 1000 4 2 1000",
                     unit_start, issue_op, issue_src, busy_units);
        end
        pulse_done(4'b1000);
    endtask

    task automatic test_fence();
        push(OP_LOAD, 4'd0, 4'd0);
        push(OP_NOP, 4'd0, 4'd0);
        push(OP_STORE, 4'd1, 4'd0);
        tick(); tick();
        n_checks++;
        if (unit_start !== 4'b0000 || fifo_level !== 3'd2 || busy_units !== 4'b0001) begin
            n_errors++;
            $display("FAIL fence_hold got start=%b lvl=%0d busy=%b want 0000 2 0001",
                     unit_start, fifo_level, busy_units);
        end
        pulse_done(4'b0001);
        tick();
        n_checks++;
        if (unit_start !== 4'b0000 || fifo_level !== 3'd1) begin
            n_errors++;
            $display("FAIL fence_pop_nop got start=%b lvl=%0d want 0000 1", unit_start, fifo_level);
        end
        tick();
        n_checks++;
        if (unit_start !== 4'b0010 || issue_op !== OP_STORE) begin
            n_errors++;
            $display("FAIL fence_store got start=%b op=%0d want 0010 2", unit_start, issue_op);
        end
        pulse_done(4'b0010);
    endtask

    task automatic test_full();
        int accepted;
        accepted = 0;
        push(OP_LOAD, 4'd0, 4'd0);
        tick();
        for (int i = 0; i < 5; i++) begin
            cmd_valid = 1'b1; cmd_decode_ok = 1'b1; cmd_op = OP_LOAD;
            cmd_unit_id = 4'd0; cmd_src_unit_id = 4'd0;
            if (cmd_ready) accepted++;
            tick();
        end
        cmd_valid = 1'b0;
        n_checks++;
        if (accepted != 4 || fifo_level !== 3'd4 || cmd_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL full_level got acc=%0d lvl=%0d rdy=%b want 4 4 0", accepted, fifo_level, cmd_ready);
        end
        for (int i = 0; i < 4; i++) begin
            pulse_done(4'b0001);
            tick();
            n_checks++;
            if (fifo_level !== 3'(3 - i) || unit_start !== 4'b0001) begin
                n_errors++;
                $display("FAIL full_drain_%0d got lvl=%0d start=%b want %0d 0001",
                         i, fifo_level, unit_start, 3 - i);
            end
        end
        pulse_done(4'b0001);
        n_checks++;
        if (sched_idle !== 1'b1 || err_status !== 3'b000) begin
            n_errors++;
            $display("FAIL full_idle got idle=%b err=%b want 1 000", sched_idle, err_status);
        end
    endtask

    task automatic test_errors();
        push(OP_LOAD, 4'd7, 4'd0);
        tick();
        n_checks++;
        if (err_status !== 3'b001 || err_count !== 8'd1 || unit_start !== 4'b0 || fifo_level !== 3'd0) begin
            n_errors++;
            $display("FAIL err_bad_unit got err=%b cnt=%0d start=%b lvl=%0d want 001 1 0000 0",
                     err_status, err_count, unit_start, fifo_level);
        end
        cmd_valid = 1'b1; cmd_decode_ok = 1'b0; cmd_op = OP_LOAD; cmd_unit_id = 4'd0;
        tick();
        cmd_valid = 1'b0; cmd_decode_ok = 1'b1;
        pulse_done(4'b1000);
        tick();
        n_checks++;
        if (err_status !== 3'b111 || err_count !== 8'd3 || unit_start !== 4'b0 || fifo_level !== 3'd0) begin
            n_errors++;
            $display("FAIL err_all got err=%b cnt=%0d start=%b lvl=%0d want 111 3 0000 0",
                     err_status, err_count, unit_start, fifo_level);
        end
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        n_checks++;
        if (err_status !== 3'b000 || err_count !== 8'd0) begin
            n_errors++;
            $display("FAIL err_clear got err=%b cnt=%0d want 000 0", err_status, err_count);
        end
        pulse_done(4'b1111);
        n_checks++;
        if (err_status !== 3'b100 || err_count !== 8'd4) begin
            n_errors++;
            $display("FAIL err_multi got err=%b cnt=%0d want 100 4", err_status, err_count);
        end
        err_clr = 1'b1; unit_done = 4'b0001;
        tick();
        err_clr = 1'b0; unit_done = 4'b0000;
        n_checks++;
        if (err_status !== 3'b000 || err_count !== 8'd0) begin
            n_errors++;
            $display("FAIL err_clr_priority got err=%b cnt=%0d want 000 0", err_status, err_count);
        end
    endtask

    task automatic test_flush();
        push(OP_LOAD, 4'd0, 4'd0);
        push(OP_LOAD, 4'd0, 4'd0);
        push(OP_LOAD, 4'd0, 4'd0);
        push(OP_LOAD, 4'd0, 4'd0);
        n_checks++;
        if (fifo_level !== 3'd3 || busy_units !== 4'b0001) begin
            n_errors++;
            $display("FAIL flush_setup got lvl=%0d busy=%b want 3 0001", fifo_level, busy_units);
        end
        flush = 1'b1;
        #1;
        n_checks++;
        if (cmd_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL flush_ready got %b want 0", cmd_ready);
        end
        tick();
        flush = 1'b0;
        n_checks++;
        if (fifo_level !== 3'd0 || busy_units !== 4'b0001 || unit_start !== 4'b0) begin
            n_errors++;
            $display("FAIL flush_empty got lvl=%0d busy=%b start=%b want 0 0001 0000",
                     fifo_level, busy_units, unit_start);
        end
        pulse_done(4'b0001);
        tick(); tick();
        n_checks++;
        if (unit_start !== 4'b0 || sched_idle !== 1'b1) begin
            n_errors++;
            $display("FAIL flush_no_start got start=%b idle=%b want 0000 1", unit_start, sched_idle);
        end
    endtask

    task automatic test_mid_reset();
        push(OP_LOAD, 4'd2, 4'd0);
        push(OP_STORE, 4'd2, 4'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        n_checks++;
        if (busy_units !== 4'b0 || fifo_level !== 3'd0 || unit_start !== 4'b0 || sched_idle !== 1'b1) begin
            n_errors++;
            $display("FAIL mid_reset got busy=%b lvl=%0d start=%b idle=%b want 0000 0 0000 1",
                     busy_units, fifo_level, unit_start, sched_idle);
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_back_to_back();
        test_copy_stall();
        test_fence();
        test_full();
        test_errors();
        test_flush();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
